// File: rtl/rca_frame_accum.sv
// Frame accumulator wrapped around an external 32-bit ripple-carry adder.
// Sums FRAME_LEN samples into a 40-bit result with a sticky wrap flag and
// presents it downstream over a valid/ready handshake.
module rca_frame_accum #(
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_cin,
  input  logic [31:0] add_sum,
  input  logic        add_cout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [39:0] out_sum,
  output logic        out_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [15:0] LAST_CNT = 16'(FRAME_LEN - 1);

  state_t      state_q, state_d;
  logic [31:0] acc_lo_q, acc_lo_d;
  logic [7:0]  ext_q, ext_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [39:0] out_sum_q, out_sum_d;
  logic        out_ovf_q, out_ovf_d;
  logic        out_valid_q, out_valid_d;

  logic [7:0]  ext_next;
  logic        ovf_next;

  // Adder carry-out feeds the 8-bit extension; a carry out of the extension
  // itself is the 40-bit wrap, which stays flagged for the rest of the frame.
  assign ext_next = 8'(ext_q + {7'b0, add_cout});
  assign ovf_next = ovf_q | ((ext_q == 8'hFF) & add_cout);

  assign in_ready  = (state_q == ACC);
  assign busy      = (state_q != IDLE);
  assign add_a     = acc_lo_q;
  assign add_b     = (state_q == ACC) ? in_data : '0;
  assign add_cin   = 1'b0;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

  always_comb begin
    state_d     = state_q;
    acc_lo_d    = acc_lo_q;
    ext_d       = ext_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_lo_d = '0;
          ext_d    = '0;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          state_d  = ACC;
        end
      end
      ACC: begin
        if (in_valid) begin
          acc_lo_d = add_sum;
          ext_d    = ext_next;
          ovf_d    = ovf_next;
          cnt_d    = cnt_q + 16'd1;
          if (cnt_q == LAST_CNT) begin
            out_sum_d   = {ext_next, add_sum};
            out_ovf_d   = ovf_next;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_lo_q    <= '0;
      ext_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_lo_q    <= acc_lo_d;
      ext_q       <= ext_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_rca_frame_accum.sv
// Bench for rca_frame_accum: four instances (FRAME_LEN 8, 4, 300, 1), each
// closed through a behavioural adder; results scored against a queue.
module tb_rca_frame_accum;

  localparam int NI = 4;
  localparam int FL [NI] = '{8, 4, 300, 1};

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NI-1:0] start, in_valid, in_ready, add_cin, add_cout;
  logic [NI-1:0] out_valid, out_ready, out_ovf, busy;
  logic [31:0]   in_data [NI];
  logic [31:0]   add_a   [NI];
  logic [31:0]   add_b   [NI];
  logic [31:0]   add_sum [NI];
  logic [39:0]   out_sum [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign {add_cout[g], add_sum[g]} =
      {1'b0, add_a[g]} + {1'b0, add_b[g]} + {32'b0, add_cin[g]};

    rca_frame_accum #(.FRAME_LEN(FL[g])) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start[g]),
      .in_valid (in_valid[g]),
      .in_data  (in_data[g]),
      .in_ready (in_ready[g]),
      .add_a    (add_a[g]),
      .add_b    (add_b[g]),
      .add_cin  (add_cin[g]),
      .add_sum  (add_sum[g]),
      .add_cout (add_cout[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .out_sum  (out_sum[g]),
      .out_ovf  (out_ovf[g]),
      .busy     (busy[g])
    );
  end

  typedef struct packed {
    logic [31:0] inst;
    logic [39:0] sum;
    logic        ovf;
  } exp_t;

  exp_t            sb [$];
  int              n_chk  = 0;
  int              n_fail = 0;
  longint unsigned msum;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: one pop per accepted result.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (out_valid[i] && out_ready[i]) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_out", {63'b0, out_valid[i]}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_inst", 64'(i), {32'b0, e.inst});
          check("sb_sum", {24'b0, out_sum[i]}, {24'b0, e.sum});
          check("sb_ovf", {63'b0, out_ovf[i]}, {63'b0, e.ovf});
        end
      end
    end
  end

  task automatic start_frame(input int i);
    in_valid[i] = 1'b1;
    in_data[i]  = 32'hDEAD_BEEF;
    #1;
    check("idle_in_ready", {63'b0, in_ready[i]}, 64'd0);
    check("idle_add_b", {32'b0, add_b[i]}, 64'd0);
    start[i] = 1'b1;
    tick();
    start[i]    = 1'b0;
    in_valid[i] = 1'b0;
    check("acc_busy", {63'b0, busy[i]}, 64'd1);
    check("acc_in_ready", {63'b0, in_ready[i]}, 64'd1);
    msum = 0;
  endtask

  task automatic send(input int i, input logic [31:0] d, input int gap, input bit last,
                      input logic [39:0] exp_sum, input bit exp_ovf);
    for (int k = 0; k < gap; k++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = 32'h5555_AAAA;
      tick();
      check("gap_in_ready", {63'b0, in_ready[i]}, 64'd1);
      check("gap_out_valid", {63'b0, out_valid[i]}, 64'd0);
    end
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    #1;
    check("acc_add_a", {32'b0, add_a[i]}, {32'b0, msum[31:0]});
    check("acc_add_b", {32'b0, add_b[i]}, {32'b0, d});
    check("acc_add_cin", {63'b0, add_cin[i]}, 64'd0);
    msum = msum + 64'(d);
    if (last) begin
      exp_t e;
      e.inst = 32'(i);
      e.sum  = msum[39:0];
      e.ovf  = |msum[63:40];
      sb.push_back(e);
    end
    tick();
    in_valid[i] = 1'b0;
    if (last) begin
      check("latency_out_valid", {63'b0, out_valid[i]}, 64'd1);
      check("const_sum", {24'b0, out_sum[i]}, {24'b0, exp_sum});
      check("const_ovf", {63'b0, out_ovf[i]}, {63'b0, exp_ovf});
      check("hold_in_ready", {63'b0, in_ready[i]}, 64'd0);
    end else begin
      check("mid_out_valid", {63'b0, out_valid[i]}, 64'd0);
    end
  endtask

  // Backpressure for `hold` cycles, then handshake with start asserted
  // alongside out_ready; the block must still land in IDLE.
  task automatic drain(input int i, input int hold, input logic [39:0] exp_sum);
    for (int k = 0; k < hold; k++) begin
      check("hold_valid", {63'b0, out_valid[i]}, 64'd1);
      check("hold_sum", {24'b0, out_sum[i]}, {24'b0, exp_sum});
      check("hold_ready", {63'b0, in_ready[i]}, 64'd0);
      check("hold_busy", {63'b0, busy[i]}, 64'd1);
      check("hold_add_b", {32'b0, add_b[i]}, 64'd0);
      start[i] = k[0];
      tick();
    end
    out_ready[i] = 1'b1;
    start[i]     = 1'b1;
    tick();
    start[i] = 1'b0;
    check("post_out_valid", {63'b0, out_valid[i]}, 64'd0);
    check("post_busy", {63'b0, busy[i]}, 64'd0);
    check("post_in_ready", {63'b0, in_ready[i]}, 64'd0);
    check("post_sum_kept", {24'b0, out_sum[i]}, {24'b0, exp_sum});
    tick();
    check("post_idle", {63'b0, busy[i]}, 64'd0);
  endtask

  initial begin
    rst       = 1'b1;
    start     = '0;
    in_valid  = '0;
    out_ready = '1;
    for (int i = 0; i < NI; i++) in_data[i] = 32'h1234_5678;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) begin
      check("rst_busy", {63'b0, busy[i]}, 64'd0);
      check("rst_in_ready", {63'b0, in_ready[i]}, 64'd0);
      check("rst_out_valid", {63'b0, out_valid[i]}, 64'd0);
      check("rst_out_sum", {24'b0, out_sum[i]}, 64'd0);
      check("rst_out_ovf", {63'b0, out_ovf[i]}, 64'd0);
      check("rst_add_a", {32'b0, add_a[i]}, 64'd0);
      check("rst_add_b", {32'b0, add_b[i]}, 64'd0);
    end

    // Basic frame, FRAME_LEN=8
    start_frame(0);
    for (int k = 1; k <= 8; k++) send(0, 32'(k), 0, k == 8, 40'h00_0000_0024, 1'b0);
    drain(0, 0, 40'h00_0000_0024);

    // Carry into extension, FRAME_LEN=4
    start_frame(1);
    for (int k = 0; k < 4; k++) send(1, 32'hFFFF_FFFF, 0, k == 3, 40'h03_FFFF_FFFC, 1'b0);
    drain(1, 0, 40'h03_FFFF_FFFC);

    // Gaps and backpressure, FRAME_LEN=4
    start_frame(1);
    out_ready[1] = 1'b0;
    send(1, 32'd10, 0, 1'b0, '0, 1'b0);
    send(1, 32'd20, 1, 1'b0, '0, 1'b0);
    send(1, 32'd30, 2, 1'b0, '0, 1'b0);
    send(1, 32'd40, 1, 1'b1, 40'h00_0000_0064, 1'b0);
    drain(1, 5, 40'h00_0000_0064);

    // 40-bit overflow, FRAME_LEN=300
    start_frame(2);
    for (int k = 0; k < 300; k++) send(2, 32'hFFFF_FFFF, 0, k == 299, 40'h2B_FFFF_FED4, 1'b1);
    drain(2, 0, 40'h2B_FFFF_FED4);

    // Reset mid-frame, FRAME_LEN=8
    start_frame(0);
    for (int k = 0; k < 3; k++) send(0, 32'd5, 0, 1'b0, '0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_busy", {63'b0, busy[0]}, 64'd0);
    check("mid_rst_in_ready", {63'b0, in_ready[0]}, 64'd0);
    check("mid_rst_out_valid", {63'b0, out_valid[0]}, 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("mid_rst_no_out", {63'b0, out_valid[0]}, 64'd0);
    end
    start_frame(0);
    for (int k = 0; k < 8; k++) send(0, 32'd5, 0, k == 7, 40'h00_0000_0028, 1'b0);
    drain(0, 0, 40'h00_0000_0028);

    // FRAME_LEN=1
    start_frame(3);
    send(3, 32'd7, 0, 1'b1, 40'h00_0000_0007, 1'b0);
    drain(3, 0, 40'h00_0000_0007);

    // start inside ACC must not restart the sample count
    start_frame(1);
    send(1, 32'd1, 0, 1'b0, '0, 1'b0);
    start[1] = 1'b1;
    send(1, 32'd2, 0, 1'b0, '0, 1'b0);
    start[1] = 1'b0;
    send(1, 32'd3, 0, 1'b0, '0, 1'b0);
    send(1, 32'd4, 0, 1'b1, 40'h00_0000_000A, 1'b0);
    drain(1, 0, 40'h00_0000_000A);

    tick();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rca_frame_accum.md
Name: rca_frame_accum

Overview:
- Sequential front/back-end for the 32-bit ripple-carry adder.
- Drives the adder's operand and carry-in inputs from a running accumulator and an input sample stream. Consumes the adder's sum and carry-out.
- Sums a frame of FRAME_LEN 32-bit samples into a 40-bit result and hands it downstream over a valid/ready handshake.
- The adder itself stays external and combinational. This block owns all state.

Parameters:
- FRAME_LEN, 16, samples per frame; legal range 1..65535.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start request; honoured only in IDLE.
- in_valid  in  1  input sample valid.
- in_data  in  32  input sample, unsigned.
- in_ready  out  1  block accepts a sample this cycle.
- add_a  out  32  adder operand a = acc_lo.
- add_b  out  32  adder operand b = in_data in ACC, else 32'h0.
- add_cin  out  1  adder carry-in; constant 0.
- add_sum  in  32  adder sum (combinational return).
- add_cout  in  1  adder carry-out (combinational return).
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  40  frame sum {ext, acc_lo}.
- out_ovf  out  1  frame sum exceeded 40 bits.
- busy  out  1  high in ACC or HOLD.

Behaviour:
- State: acc_lo[31:0], ext[7:0], cnt[15:0], ovf, FSM {IDLE, ACC, HOLD}.
- Reset (rst=1 at edge):
  - FSM=IDLE.
  - acc_lo, ext, cnt, ovf, out_sum, out_ovf, out_valid all cleared to 0.
  - Takes priority over every other input.
  - Reset mid-frame discards the partial sum. No output is produced for that frame.
- Combinational outputs:
  - in_ready = (FSM==ACC).
  - busy = (FSM!=IDLE).
  - add_a, add_b, add_cin as listed under Ports.
  - No combinational path from in_valid or out_ready to in_ready.
- IDLE:
  - in_ready=0.
  - start=1 → clear acc_lo, ext, cnt, ovf; FSM=ACC next cycle.
  - in_valid ignored.
- ACC:
  - Accept occurs when in_valid=1 (in_ready=1 in this state). On accept:
    - acc_lo <= add_sum.
    - ext <= ext + add_cout, wrapping mod 256.
    - If ext==8'hFF and add_cout=1 → ovf <= 1; ovf is sticky for the frame.
    - cnt <= cnt+1.
  - No accept → all state holds. Gaps in in_valid are legal.
  - Accept with cnt==FRAME_LEN-1:
    - out_sum <= {ext_next, add_sum}; out_ovf <= ovf_next; out_valid <= 1.
    - FSM=HOLD.
  - FRAME_LEN=1: the first accept completes the frame.
  - start ignored in ACC.
- HOLD:
  - in_ready=0.
  - out_valid=1, and out_sum/out_ovf are stable until out_ready=1.
  - out_ready=1 → out_valid <= 0 and FSM=IDLE.
  - start asserted in the same cycle as out_ready, or at any time in HOLD, is ignored. A new frame needs start in IDLE.
  - out_ready=0 → hold indefinitely.
- Latency: out_valid rises the cycle after the last sample is accepted.
- Throughput: one sample per cycle. Minimum frame period is FRAME_LEN+2 cycles (start, samples, handshake).
- Arithmetic: unsigned only; add_cin is always 0. The 40-bit result wraps modulo 2^40, with out_ovf flagging the wrap.
- out_sum and out_ovf retain their last value in IDLE. They are meaningful only while out_valid=1.

Test Plan:
- Basic frame, FRAME_LEN=8: start, then samples 1..8 back-to-back with out_ready=1 → out_valid for 1 cycle, out_sum=40'h00_00000024, out_ovf=0, FSM back in IDLE; also check add_b=0 outside ACC.
- Carry into extension, FRAME_LEN=4: four samples of 32'hFFFFFFFF → out_sum=40'h03_FFFFFFFC, out_ovf=0.
- Input gaps and backpressure, FRAME_LEN=4: samples 10,20,30,40 with in_valid toggling; out_ready low for 5 cycles → out_sum=40'h00_00000064 held stable and out_valid high until the out_ready cycle; start pulses during HOLD ignored; in_ready=0 throughout HOLD.
- 40-bit overflow, FRAME_LEN=300: 300 samples of 32'hFFFFFFFF → out_sum=40'h2B_FFFFFED4, out_ovf=1.
- Reset mid-frame, FRAME_LEN=8: rst after 3 of 8 samples → next cycle IDLE, in_ready=0, no out_valid; a new frame of 8×5 → out_sum=40'h00_00000028, proving state was cleared.
- FRAME_LEN=1 and start-ignore: start then sample 7 → out_sum=40'h00_00000007 one cycle later; start re-asserted while in ACC of a separate frame has no effect on cnt.
